// File: rtl/fifo_skew_reader.sv
// Drains ROWS operand FIFOs onto the systolic array edge with a diagonal skew:
// row r pops its k-th word at step k+r, all rows advancing in lockstep.
module fifo_skew_reader #(
   parameter int ROWS       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LEN_WIDTH-1:0]       len,
   input  logic [ROWS-1:0]            empty,
   input  logic [ROWS*DATA_WIDTH-1:0] rdata,
   output logic [ROWS-1:0]            ren,
   output logic [ROWS*DATA_WIDTH-1:0] out_data,
   output logic [ROWS-1:0]            out_valid,
   output logic                       busy,
   output logic                       done
);

   // Wide enough to hold len+ROWS-1 without wrapping.
   localparam int CW = LEN_WIDTH + $clog2(ROWS) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_reg;
   logic [CW-1:0]        c_reg;
   logic [LEN_WIDTH-1:0] len_reg;
   logic [ROWS-1:0]      active;
   logic                 stall;
   logic [CW-1:0]        last_step;

   assign last_step = CW'(len_reg) + CW'(ROWS) - CW'(2);

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         logic [DATA_WIDTH-1:0] data_reg;
         logic                  valid_reg;

         assign active[gi] = (state_reg == RUN) && (c_reg >= CW'(gi)) &&
                             (c_reg < CW'(gi) + CW'(len_reg));

         // Idle or stalled rows emit a zero bubble rather than holding old data.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_reg  <= '0;
               valid_reg <= 1'b0;
            end else if (ren[gi]) begin
               data_reg  <= rdata[gi*DATA_WIDTH +: DATA_WIDTH];
               valid_reg <= 1'b1;
            end else begin
               data_reg  <= '0;
               valid_reg <= 1'b0;
            end
         end

         assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
         assign out_valid[gi]                         = valid_reg;
      end
   endgenerate

   // Any active row running dry freezes all rows so the skew stays intact.
   assign stall = |(active & empty);
   assign ren   = stall ? '0 : active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         c_reg     <= '0;
         len_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     state_reg <= DONE;
                  end else begin
                     state_reg <= RUN;
                     len_reg   <= len;
                     c_reg     <= '0;
                  end
               end
            end
            RUN: begin
               if (!stall) begin
                  c_reg <= c_reg + CW'(1);
                  if (c_reg == last_step) state_reg <= DONE;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Bench for fifo_skew_reader: queue-backed FIFOs, a per-row pop-count model of
// the skewed schedule, directed cases followed by randomized traffic.
module tb_fifo_skew_reader;

   localparam int ROWS = 4;
   localparam int DW   = 8;
   localparam int LW   = 8;
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [LW-1:0]        len = '0;
   logic [ROWS-1:0]      empty = '0;
   logic [ROWS*DW-1:0]   rdata = '0;
   logic [ROWS-1:0]      ren;
   logic [ROWS*DW-1:0]   out_data;
   logic [ROWS-1:0]      out_valid;
   logic                 busy;
   logic                 done;

   fifo_skew_reader #(.ROWS(ROWS), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .empty(empty),
      .rdata(rdata), .ren(ren), .out_data(out_data), .out_valid(out_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_checks++;
      if (obs === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, req, $time);
   endtask

   // Reference state: FIFO contents, tile progress as per-row pop counts.
   logic [DW-1:0]      fq [ROWS][$];
   int                 m_state = M_IDLE;
   int                 m_step  = 0;
   int                 m_len   = 0;
   int                 pops_m   [ROWS];
   int                 pops_dut [ROWS];
   logic [ROWS-1:0]    exp_ov = '0;
   logic [ROWS*DW-1:0] exp_od = '0;

   task automatic run_cycle(input logic st, input logic [LW-1:0] ln, input logic [ROWS-1:0] force_e);
      logic [ROWS-1:0]    act;
      logic [ROWS-1:0]    e_ren;
      logic [ROWS-1:0]    emp_v;
      logic [ROWS*DW-1:0] rd_v;
      logic               stl;
      int                 total;
      @(negedge clk);
      chk("out_valid", out_valid, exp_ov);
      chk("out_data", out_data, exp_od);
      chk("busy", busy, m_state == M_RUN);
      chk("done", done, m_state == M_DONE);
      for (int r = 0; r < ROWS; r++) begin
         while (fq[r].size() < 4) fq[r].push_back(DW'($urandom));
         emp_v[r] = force_e[r];
         rd_v[r*DW +: DW] = fq[r][0];
      end
      start = st;
      len   = ln;
      empty = emp_v;
      rdata = rd_v;
      #1;
      // A row is due while it has words left and its skew offset has elapsed.
      for (int r = 0; r < ROWS; r++)
         act[r] = (m_state == M_RUN) && (m_step >= r) && (pops_m[r] < m_len);
      stl   = |(act & emp_v);
      e_ren = stl ? '0 : act;
      chk("ren", ren, e_ren);
      exp_ov = '0;
      exp_od = '0;
      total  = 0;
      for (int r = 0; r < ROWS; r++) begin
         pops_dut[r] += int'(ren[r]);
         if (e_ren[r]) begin
            exp_ov[r] = 1'b1;
            exp_od[r*DW +: DW] = fq[r].pop_front();
            pops_m[r]++;
         end
         total += pops_m[r];
      end
      case (m_state)
         M_IDLE: if (st) begin
            if (ln == '0) begin
               m_state = M_DONE;
               $display("tile len=0 accepted at t=%0t", $time);
            end else begin
               m_state = M_RUN;
               m_len   = int'(ln);
               m_step  = 0;
               for (int r = 0; r < ROWS; r++) begin
                  pops_m[r]   = 0;
                  pops_dut[r] = 0;
               end
            end
         end
         M_RUN: if (!stl) begin
            m_step++;
            if (total == ROWS * m_len) begin
               for (int r = 0; r < ROWS; r++) chk("row_pops", pops_dut[r], m_len);
               m_state = M_DONE;
               $display("tile len=%0d drained at t=%0t", m_len, $time);
            end
         end
         default: m_state = M_IDLE;
      endcase
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b0, LW'($urandom_range(0, 9)), '0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_ren", ren, '0);
      chk("rst_out_valid", out_valid, '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      start   = 1'b0;
      m_state = M_IDLE;
      exp_ov  = '0;
      exp_od  = '0;
      $display("reset applied at t=%0t", $time);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("init_ren", ren, '0);
      chk("init_out_valid", out_valid, '0);
      chk("init_busy", busy, 1'b0);
      chk("init_done", done, 1'b0);
      #1 rst = 1'b0;

      // Baseline len=3, then a start landing on DONE, then the accepted restart.
      run_cycle(1'b1, 8'd3, '0);
      for (int i = 1; i < 7; i++) run_cycle(1'b0, 8'd0, '0);
      run_cycle(1'b1, 8'd2, '0);
      run_cycle(1'b1, 8'd2, '0);
      idle_cycles(7);

      // Active row 2 empty for two cycles.
      run_cycle(1'b1, 8'd3, '0);
      for (int i = 1; i < 10; i++) run_cycle(1'b0, 8'd0, (i == 3 || i == 4) ? 4'b0100 : 4'b0000);
      idle_cycles(2);

      // Inactive row 3 empty early: no stall.
      run_cycle(1'b1, 8'd3, 4'b1000);
      for (int i = 1; i < 8; i++) run_cycle(1'b0, 8'd0, (i <= 3) ? 4'b1000 : 4'b0000);
      idle_cycles(2);

      // Zero-length tile.
      run_cycle(1'b1, 8'd0, '0);
      idle_cycles(3);

      // Restart during RUN is ignored.
      run_cycle(1'b1, 8'd3, '0);
      run_cycle(1'b0, 8'd0, '0);
      run_cycle(1'b1, 8'd5, '0);
      idle_cycles(7);

      // Reset partway through a tile.
      run_cycle(1'b1, 8'd4, '0);
      for (int i = 1; i < 5; i++) run_cycle(1'b0, 8'd0, '0);
      do_reset();
      idle_cycles(3);

      // Randomized traffic: sporadic starts (often ignored), random empties.
      for (int i = 0; i < 1500; i++) begin
         logic [ROWS-1:0] fe;
         for (int r = 0; r < ROWS; r++) fe[r] = ($urandom_range(0, 7) == 0);
         run_cycle($urandom_range(0, 3) == 0, LW'($urandom_range(0, 6)), fe);
      end
      idle_cycles(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_skew_reader.md
# fifo_skew_reader

Drains ROWS parallel operand FIFOs into the systolic array edge with a diagonal skew: row r issues its k-th read at schedule step k + r. It sits directly downstream of the per-row FIFO read-side logic. It consumes each FIFO's `empty` flag and head data, and drives each FIFO's `ren`. It registers the popped words onto the array boundary, inserting zero bubbles where a row is idle. A single tile of `len` words per row is drained per `start`.

## Interface
- ROWS, 4, number of FIFO rows / array rows
- DATA_WIDTH, 8, width of one operand word
- LEN_WIDTH, 8, width of the tile-length input
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a tile drain; sampled only in IDLE
- len  input  LEN_WIDTH  words per row for this tile; latched on accepted `start`
- empty  input  ROWS  per-row FIFO empty flag
- rdata  input  ROWS*DATA_WIDTH  per-row FIFO head word (first-word fall-through); row r in bits [r*DATA_WIDTH +: DATA_WIDTH]; valid whenever `empty[r]`=0
- ren  output  ROWS  per-row pop strobe, combinational
- out_data  output  ROWS*DATA_WIDTH  registered operand to array, same row packing as `rdata`
- out_valid  output  ROWS  registered per-row valid
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse at tile completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when `start`=1 and `len`!=0. Latches `len` and clears step counter `c` to 0.
- IDLE -> DONE when `start`=1 and `len`=0. No reads are issued.
- RUN -> DONE when `c` = len+ROWS-2 and no stall this cycle.
- DONE -> IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored, and `len` is not re-latched.
- Step counter `c` is LEN_WIDTH+$clog2(ROWS)+1 bits wide, so it never wraps for any len/ROWS.
- Row r is active in RUN when r <= c < r+len.
- stall = OR over rows of (active[r] & empty[r]).
- ren[r] = RUN & active[r] & ~stall. Rows advance in lockstep, so an empty active row freezes every row and the skew is preserved.
- `c` increments by 1 on each RUN cycle without stall and holds on stall.
- Output register, per row each cycle:
  - If ren[r]: out_data[r] <= rdata[r] and out_valid[r] <= 1.
  - Otherwise: out_data[r] <= 0 and out_valid[r] <= 0, which forms a zero bubble.
- `busy` = (state==RUN). `done` = (state==DONE).
- Each row performs exactly `len` pops per tile. The total is ROWS*len pops.

## Timing
- Reset (async, immediate): state=IDLE, c=0, latched len=0, out_data=0, out_valid=0, busy=0, done=0. `ren`=0 as soon as rst asserts.
- Reset mid-RUN aborts the tile with no done pulse. Any FIFO contents already popped are lost; unpopped contents remain.
- Latency: `start` sampled at edge E0. RUN begins after E0. First possible `ren[0]` is in the cycle after E0. The matching `out_valid[0]` appears one cycle later.
- `ren` to `out_valid`/`out_data`: exactly 1 cycle.
- With no stalls, RUN lasts len+ROWS-1 cycles. DONE follows immediately and coincides with the final `out_valid[ROWS-1]`.
- A stall of S cycles lengthens RUN by exactly S. During a stall, every row's `out_valid` is 0 on the next cycle.
- An empty flag on an inactive row never stalls.
- A `start` coinciding with the DONE cycle is ignored. The earliest accepted restart is sampled in the following IDLE cycle.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> ren=0 immediately; all outputs 0; state IDLE after release.
- ROWS=4, len=3, all FIFOs non-empty, start at cycle 0 -> required response:
  - ren patterns in cycles 1..6: 0001, 0011, 0111, 1110, 1100, 1000.
  - out_valid shows the same patterns in cycles 2..7.
  - done=1 in cycle 7; busy=1 in cycles 1..6.
  - Each row pops exactly 3 words.
- Same setup, empty[2]=1 during cycles 3–4 (row 2 active) -> ren=0000 in cycles 3–4; `c` held; out_valid=0000 in cycles 4–5; done moves to cycle 9; words arrive in order with skew intact.
- empty[3]=1 throughout cycles 1–3 while row 3 is inactive -> no stall; timing identical to the baseline case.
- start with len=0 -> no ren ever; done=1 for one cycle, the cycle after start; busy stays 0.
- start pulsed again during RUN with a different len -> ignored; tile finishes with the original len; rst asserted at cycle 4 of a tile -> no done; outputs cleared immediately.
